// File: rtl/wb_pkg.sv
// wb_pkg: shared types and defaults for the register-file write-port arbiter.
//   wb_entry_t   - queued long-latency result {rd, data}
//   REG_ZERO     - index of the hardwired-zero register
//   DEFAULT_*    - default response-queue depth and starvation limit
//   reg_mask()   - one-hot register mask that never selects register 0
package wb_pkg;

    localparam int DEFAULT_DEPTH        = 2;
    localparam int DEFAULT_STARVE_LIMIT = 4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    // Register 0 is never tracked, so its mask is empty.
    function automatic logic [31:0] reg_mask(input logic [4:0] rd);
        reg_mask = (rd == REG_ZERO) ? 32'd0 : (32'd1 << rd);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t holding long-latency results until
// the register-file write port is free.
//   clk, rst    - clock, synchronous active-high reset
//   push        - write push_entry at the edge (ignored when full)
//   push_entry  - entry to enqueue
//   pop         - drop the head at the edge (ignored when empty)
//   head        - oldest entry (valid when empty=0)
//   full, empty - occupancy flags
//   count       - number of stored entries, 0..DEPTH
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_entry_t     push_entry,
    input  logic          pop,
    output wb_entry_t     head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    wb_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage is not reset; an entry is only ever read after it was
    // written, and the pointers/count below carry all valid state.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are AW bits wide, so DEPTH being a power of two makes
            // the increment wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: drives the register file's single write port, merging the
// in-order pipeline writeback with queued long-latency results, and tracks
// which registers are still owed a long-latency result.
//   clk, rst                     - clock, synchronous active-high reset
//   pipe_valid/rd/data           - pipeline writeback (no backpressure)
//   lu_issue_valid/rd            - long-latency op issued, claims rd
//   lu_resp_valid/rd/data        - long-latency result offered
//   lu_resp_ready                - response queue can accept this cycle
//   hold_pipe                    - upstream must idle the pipeline writeback
//   busy                         - per-register "result still owed" bits
//   load, dest, in               - register-file write enable/index/data
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        lu_issue_valid,
    input  logic [4:0]  lu_issue_rd,
    input  logic        lu_resp_valid,
    input  logic [4:0]  lu_resp_rd,
    input  logic [31:0] lu_resp_data,
    output logic        lu_resp_ready,
    output logic        hold_pipe,
    output logic [31:0] busy,
    output logic        load,
    output logic [4:0]  dest,
    output logic [31:0] in
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t     head;
    wb_entry_t     resp_entry;
    logic          q_full;
    logic          q_empty;
    logic [CW-1:0] q_count;
    logic          push;
    logic          pop;
    logic          pipe_sel;
    logic          starve_hit;
    logic [SW-1:0] starve_cnt;
    logic [CW-1:0] drain_left;
    logic [31:0]   set_mask;
    logic [31:0]   clr_mask;

    // Ready comes from the registered count only, so a pop in the same cycle
    // never lets a new response through a full queue.
    assign lu_resp_ready = !q_full;
    assign push          = lu_resp_valid && lu_resp_ready;
    assign resp_entry    = '{rd: lu_resp_rd, data: lu_resp_data};

    // A pipeline write to x0 is a no-op and leaves the port to the queue.
    assign pipe_sel = pipe_valid && (pipe_rd != REG_ZERO);
    assign pop      = !rst && !pipe_sel && !q_empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (resp_entry),
        .pop        (pop),
        .head       (head),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count)
    );

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        load = 1'b0;
        dest = '0;
        in   = '0;
        if (!rst) begin
            if (pipe_sel) begin
                load = 1'b1;
                dest = pipe_rd;
                in   = pipe_data;
            end else if (pop && head.rd != REG_ZERO) begin
                load = 1'b1;
                dest = head.rd;
                in   = head.data;
            end
        end
    end

    // The counter reaches STARVE_LIMIT at this edge; hold_pipe rises with it.
    assign starve_hit = !q_empty && !pop && (starve_cnt == SW'(STARVE_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            hold_pipe  <= 1'b0;
            drain_left <= '0;
        end else begin
            if (q_empty || pop) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            // While held, only the entries queued when the hold started must
            // drain; later arrivals do not extend the bubble.
            if (hold_pipe) begin
                if (pop) begin
                    drain_left <= drain_left - CW'(1);
                    if (drain_left == CW'(1)) hold_pipe <= 1'b0;
                end
            end else if (starve_hit) begin
                hold_pipe  <= 1'b1;
                drain_left <= q_count + CW'(push);
            end
        end
    end

    // A new claim and a retiring result on the same register: the claim wins.
    assign set_mask = lu_issue_valid ? reg_mask(lu_issue_rd) : '0;
    assign clr_mask = pop ? reg_mask(head.rd) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed stimulus with a write scoreboard. Stimulus
// pushes each expected register-file write into exp_q; the monitor pops and
// compares whenever the DUT asserts load, and also watches the protocol rules.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    logic        clk;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lu_issue_valid;
    logic [4:0]  lu_issue_rd;
    logic        lu_resp_valid;
    logic [4:0]  lu_resp_rd;
    logic [31:0] lu_resp_data;
    logic        lu_resp_ready;
    logic        hold_pipe;
    logic [31:0] busy;
    logic        wr_load;
    logic [4:0]  wr_dest;
    logic [31:0] wr_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;
    wb_entry_t   exp_q[$];
    wb_entry_t   mon_e;

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .pipe_valid     (pipe_valid),
        .pipe_rd        (pipe_rd),
        .pipe_data      (pipe_data),
        .lu_issue_valid (lu_issue_valid),
        .lu_issue_rd    (lu_issue_rd),
        .lu_resp_valid  (lu_resp_valid),
        .lu_resp_rd     (lu_resp_rd),
        .lu_resp_data   (lu_resp_data),
        .lu_resp_ready  (lu_resp_ready),
        .hold_pipe      (hold_pipe),
        .busy           (busy),
        .load           (wr_load),
        .dest           (wr_dest),
        .in             (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_valid     = 1'b0;
        pipe_rd        = '0;
        pipe_data      = '0;
        lu_issue_valid = 1'b0;
        lu_issue_rd    = '0;
        lu_resp_valid  = 1'b0;
        lu_resp_rd     = '0;
        lu_resp_data   = '0;
    endtask

    task automatic issue(input logic [4:0] rd);
        lu_issue_valid = 1'b1;
        lu_issue_rd    = rd;
    endtask

    task automatic resp(input logic [4:0] rd, input logic [31:0] data);
        lu_resp_valid = 1'b1;
        lu_resp_rd    = rd;
        lu_resp_data  = data;
    endtask

    task automatic pipe(input logic [4:0] rd, input logic [31:0] data);
        pipe_valid = 1'b1;
        pipe_rd    = rd;
        pipe_data  = data;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back('{rd: rd, data: data});
    endtask

    // Monitor: compares every write against the scoreboard and checks the
    // upstream protocol rules each cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_load) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {27'd0, wr_dest, wr_data}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write", {27'd0, wr_dest, wr_data}, {27'd0, mon_e.rd, mon_e.data});
                end
            end else begin
                check("idle_port_zero", {27'd0, wr_dest, wr_data}, 64'd0);
            end
            if (!rst) begin
                if (pipe_valid)
                    check("no_pipe_during_hold", hold_pipe, 0);
                if (pipe_valid && pipe_rd != 0)
                    check("pipe_to_free_reg", busy[pipe_rd], 0);
                if (lu_resp_valid && lu_resp_rd != 0)
                    check("resp_to_busy_reg", busy[lu_resp_rd], 1);
                if (lu_issue_valid && lu_issue_rd != 0 && !(wr_load && wr_dest == lu_issue_rd))
                    check("issue_to_free_reg", busy[lu_issue_rd], 0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_hold", hold_pipe, 0);
        check("reset_ready", lu_resp_ready, 1);
        check("reset_load", wr_load, 0);

        // Response only: issue 5, respond 5/DEADBEEF, written one cycle later.
        tick(); idle(); issue(5'd5);
        @(negedge clk); check("t1_busy5_pre", busy[5], 0);
        tick(); idle();
        @(negedge clk); check("t1_busy5_set", busy[5], 1);
        tick(); idle(); resp(5'd5, 32'hDEAD_BEEF); push_exp(5'd5, 32'hDEAD_BEEF);
        @(negedge clk); check("t1_no_write_on_arrival", wr_load, 0);
        check("t1_ready", lu_resp_ready, 1);
        tick(); idle();
        @(negedge clk); check("t1_busy5_during_write", busy[5], 1);
        tick();
        @(negedge clk); check("t1_busy5_cleared", busy[5], 0);

        // Collision: queued 7 waits behind pipeline write to 3.
        tick(); idle(); issue(5'd7);
        tick(); idle(); resp(5'd7, 32'h7777_0007);
        push_exp(5'd3, 32'h11); push_exp(5'd7, 32'h7777_0007);
        tick(); idle(); pipe(5'd3, 32'h11);
        @(negedge clk); check("t2_busy7_blocked", busy[7], 1);
        tick(); idle();
        @(negedge clk); check("t2_busy7_during_write", busy[7], 1);
        tick();
        @(negedge clk); check("t2_busy7_cleared", busy[7], 0);

        // Full queue under continuous pipeline writes.
        tick(); idle(); issue(5'd10);
        tick(); idle(); issue(5'd11);
        tick(); idle(); pipe(5'd20, 32'h20); resp(5'd10, 32'hA);
        push_exp(5'd20, 32'h20); push_exp(5'd21, 32'h21); push_exp(5'd22, 32'h22);
        push_exp(5'd10, 32'hA); push_exp(5'd11, 32'hB);
        @(negedge clk); check("t3_ready_empty", lu_resp_ready, 1);
        tick(); idle(); pipe(5'd21, 32'h21); resp(5'd11, 32'hB);
        @(negedge clk); check("t3_ready_one", lu_resp_ready, 1);
        tick(); idle(); pipe(5'd22, 32'h22);
        @(negedge clk); check("t3_ready_full", lu_resp_ready, 0);
        tick(); idle();
        @(negedge clk); check("t3_ready_full_pop", lu_resp_ready, 0);
        tick();
        @(negedge clk); check("t3_ready_back", lu_resp_ready, 1);
        tick();

        // Starvation: one entry, pipeline writes every cycle.
        tick(); idle(); issue(5'd12);
        for (int i = 0; i < 5; i++) begin
            tick(); idle(); pipe(5'(i + 1), 32'h100 + 32'(i));
            push_exp(5'(i + 1), 32'h100 + 32'(i));
            if (i == 0) resp(5'd12, 32'hC);
            @(negedge clk); check("t4_hold_low", hold_pipe, 0);
        end
        push_exp(5'd12, 32'hC);
        tick(); idle();
        @(negedge clk); check("t4_hold_set", hold_pipe, 1);
        tick();
        @(negedge clk); check("t4_hold_cleared", hold_pipe, 0);
        check("t4_busy12_cleared", busy[12], 0);

        // x0 response drains silently; set wins over clear on rd 9.
        tick(); idle(); resp(5'd0, 32'h55);
        @(negedge clk); check("t5_ready", lu_resp_ready, 1);
        tick(); idle();
        @(negedge clk); check("t5_x0_no_load", wr_load, 0);
        tick(); idle(); issue(5'd9);
        tick(); idle(); resp(5'd9, 32'h99); push_exp(5'd9, 32'h99);
        tick(); idle(); issue(5'd9);
        @(negedge clk); check("t5_busy9_pre", busy[9], 1);
        tick(); idle();
        @(negedge clk); check("t5_busy9_set_wins", busy[9], 1);
        check("t5_queue_drained", wr_load, 0);

        // Reset with two entries queued and hold_pipe high.
        tick(); idle(); issue(5'd13);
        tick(); idle(); issue(5'd14);
        for (int i = 0; i < 5; i++) begin
            tick(); idle(); pipe(5'(i + 1), 32'h200 + 32'(i));
            push_exp(5'(i + 1), 32'h200 + 32'(i));
            if (i == 0) resp(5'd13, 32'hD);
            if (i == 1) resp(5'd14, 32'hE);
            @(negedge clk); check("t6_hold_low", hold_pipe, 0);
        end
        tick(); idle(); rst = 1'b1;
        @(negedge clk); check("t6_hold_before_reset", hold_pipe, 1);
        check("t6_no_write_in_reset", wr_load, 0);
        tick(); rst = 1'b0;
        @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_hold", hold_pipe, 0);
        check("t6_ready", lu_resp_ready, 1);
        check("t6_load", wr_load, 0);
        check("t6_dest", wr_dest, 0);
        check("t6_in", wr_data, 0);
        tick();
        @(negedge clk); check("t6_no_stale_write", wr_load, 0);

        check("leftover_expected_writes", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
